// File: rtl/and_pair_sched.sv
// Two-operand launch/capture scheduler: holds A and B until both have arrived, waits
// B_DELAY alignment cycles, then captures A&B into a registered valid/ready output.
module and_pair_sched #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned B_DELAY = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             busy
);

  if (B_DELAY > 7) begin : g_bad_b_delay
    $error("and_pair_sched: B_DELAY must be within 0..7");
  end

  localparam logic [2:0] DlyInit = 3'(B_DELAY);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHaveA = 2'd1,
    StHaveB = 2'd2,
    StAlign = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       dly_q, dly_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;

  logic a_acc;
  logic b_acc;
  logic fire;

  assign a_acc = a_valid & a_ready;
  assign b_acc = b_valid & b_ready;

  // A result may be captured when alignment is done and the output slot is free or draining.
  assign fire = (state_q == StAlign) && (dly_q == 3'd0) && (!out_valid_q || out_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (a_acc && b_acc) begin
          state_d = StAlign;
        end else if (a_acc) begin
          state_d = StHaveA;
        end else if (b_acc) begin
          state_d = StHaveB;
        end
      end
      StHaveA: begin
        if (b_acc) state_d = StAlign;
      end
      StHaveB: begin
        if (a_acc) state_d = StAlign;
      end
      StAlign: begin
        if (fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode: readies depend on state only, never on the incoming valids.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        a_ready = 1'b1;
        b_ready = 1'b1;
      end
      StHaveA: b_ready = 1'b1;
      StHaveB: a_ready = 1'b1;
      StAlign: ;
      default: ;
    endcase
    busy = (state_q != StIdle) || out_valid_q;
  end

  // Datapath next-state
  always_comb begin
    a_d         = a_acc ? a_data : a_q;
    b_d         = b_acc ? b_data : b_q;
    dly_d       = dly_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pair_cnt_d  = pair_cnt_q;

    if (state_q != StAlign && state_d == StAlign) begin
      dly_d = DlyInit;
    end else if (state_q == StAlign && dly_q != 3'd0) begin
      dly_d = dly_q - 3'd1;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // A fire on the same edge as a drain reloads the slot without a bubble.
    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = a_q & b_q;
      pair_cnt_d  = pair_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      dly_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pair_cnt_q  <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      dly_q       <= dly_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pair_cnt_q  <= pair_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pair_cnt  = pair_cnt_q;

endmodule
